// File: rtl/beta_prefetch_buffer.sv
// beta_prefetch_buffer: sequential instruction prefetch FIFO with branch flush; define BETA_PF_BYPASS_EN for a same-cycle response bypass
module beta_prefetch_buffer #(
    parameter int DataWidth = 32,
    parameter int AddressWidth = 32,
    parameter int Depth = 4,
    parameter int MaxOutstanding = 2,
    parameter logic [AddressWidth-1:0] BootAddr = 32'h0000_0080
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    pf_en_i,
    input  logic                    pf_branch_i,
    input  logic [AddressWidth-1:0] pf_branch_addr_i,
    output logic                    pf_valid_o,
    input  logic                    pf_ready_i,
    output logic [DataWidth-1:0]    pf_instr_o,
    output logic [AddressWidth-1:0] pf_addr_o,
    output logic                    pf_busy_o,
    output logic                    instr_req_o,
    output logic [AddressWidth-1:0] instr_addr_o,
    input  logic                    instr_ready_i,
    input  logic                    instr_valid_i,
    input  logic [DataWidth-1:0]    instr_rdata_i
);
    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_OUT = CW'(MaxOutstanding);
    localparam logic [CW-1:0] DEPTH_C = CW'(Depth);
    logic [DataWidth-1:0] data_q [Depth];
    logic [AddressWidth-1:0] addr_q [Depth];
    logic [AddressWidth-1:0] shadow_q [Depth];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, swptr_q, swptr_d, srptr_q, srptr_d;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;
    logic [AddressWidth-1:0] fetch_q, fetch_d;
    logic grant, push, pop, bypass, fifo_valid;
`ifdef BETA_PF_BYPASS_EN
    assign bypass = (count_q == '0) && (discard_q == '0) && instr_valid_i && !pf_branch_i;
`else
    assign bypass = 1'b0;
`endif
    assign fifo_valid = count_q != '0;
    assign pf_valid_o = fifo_valid | bypass;
    assign pf_instr_o = fifo_valid ? data_q[rptr_q] : bypass ? instr_rdata_i : '0;
    assign pf_addr_o = fifo_valid ? addr_q[rptr_q] : bypass ? shadow_q[srptr_q] : '0;
    assign pf_busy_o = (outst_q != '0) | (discard_q != '0);
    assign instr_req_o = ~rst_i & pf_en_i & ~pf_branch_i & (outst_q < MAX_OUT) & (count_q + outst_q < DEPTH_C);
    assign instr_addr_o = fetch_q;
    assign grant = instr_req_o & instr_ready_i;
    assign pop = fifo_valid & pf_ready_i & ~pf_branch_i;
    assign push = instr_valid_i & (discard_q == '0) & ~pf_branch_i & ~(bypass & pf_ready_i);
    // next state: a branch flushes the FIFO and turns every in-flight request into a discard
    always_comb begin
        fetch_d = pf_branch_i ? pf_branch_addr_i & ~AddressWidth'(3) : grant ? fetch_q + AddressWidth'(4) : fetch_q;
        outst_d = outst_q + CW'(grant) - CW'(instr_valid_i);
        discard_d = pf_branch_i ? outst_q + CW'(grant) - CW'(instr_valid_i)
                                : discard_q - CW'(instr_valid_i && discard_q != '0);
        wptr_d = pf_branch_i ? '0 : wptr_q + PW'(push);
        rptr_d = pf_branch_i ? '0 : rptr_q + PW'(pop);
        count_d = pf_branch_i ? '0 : count_q + CW'(push) - CW'(pop);
        swptr_d = swptr_q + PW'(grant);
        srptr_d = srptr_q + PW'(instr_valid_i);
    end
    // control state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_q <= BootAddr & ~AddressWidth'(3);
            outst_q <= '0;
            discard_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            count_q <= '0;
            swptr_q <= '0;
            srptr_q <= '0;
        end else begin
            fetch_q <= fetch_d;
            outst_q <= outst_d;
            discard_q <= discard_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            count_q <= count_d;
            swptr_q <= swptr_d;
            srptr_q <= srptr_d;
        end
    end
    // entry storage and granted-address shadow queue; responses take their address from the shadow head
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wptr_q] <= instr_rdata_i;
            addr_q[wptr_q] <= shadow_q[srptr_q];
        end
        if (grant) shadow_q[swptr_q] <= fetch_q;
    end
`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (rst_i) !(push && !pop && count_q == DEPTH_C))
        else $error("prefetch FIFO overflow");
`endif
endmodule

// File: tb/tb_beta_prefetch_buffer.sv
// tb_beta_prefetch_buffer: table, directed and random checks against a queue-based reference model
module tb_beta_prefetch_buffer;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic pf_en_i = 1'b0, pf_branch_i = 1'b0, pf_ready_i = 1'b0, instr_ready_i = 1'b0, instr_valid_i = 1'b0;
    logic [31:0] pf_branch_addr_i = '0, instr_rdata_i = '0;
    logic pf_valid_o, pf_busy_o, instr_req_o;
    logic [31:0] pf_instr_o, pf_addr_o, instr_addr_o;
    always #5 clk_i = ~clk_i;
    beta_prefetch_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i), .pf_en_i(pf_en_i), .pf_branch_i(pf_branch_i),
        .pf_branch_addr_i(pf_branch_addr_i), .pf_valid_o(pf_valid_o), .pf_ready_i(pf_ready_i),
        .pf_instr_o(pf_instr_o), .pf_addr_o(pf_addr_o), .pf_busy_o(pf_busy_o),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_ready_i(instr_ready_i),
        .instr_valid_i(instr_valid_i), .instr_rdata_i(instr_rdata_i)
    );
    typedef struct { logic [31:0] addr; logic [31:0] data; logic drop; } ent_t;
    typedef struct { int rep; logic rdy; logic req; logic [31:0] iaddr; logic valid; logic [31:0] paddr; } vec_t;
    ent_t q[$];
    ent_t f[$];
    logic [31:0] m_fetch = 32'h80;
    int n_chk = 0, n_fail = 0;
    logic s_req, s_valid, s_busy;
    logic [31:0] s_iaddr, s_paddr, s_instr;
    vec_t tbl[10];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic apply_reset();
        pf_en_i = 1'b1; pf_branch_i = 1'b0; pf_ready_i = 1'b1;
        instr_ready_i = 1'b1; instr_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst instr_req_o", instr_req_o, 0);
        chk("rst pf_valid_o", pf_valid_o, 0);
        chk("rst pf_busy_o", pf_busy_o, 0);
        chk("rst pf_instr_o", pf_instr_o, 0);
        chk("rst pf_addr_o", pf_addr_o, 0);
        chk("rst instr_addr_o", instr_addr_o, 32'h80);
        q.delete();
        f.delete();
        m_fetch = 32'h80;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask
    task automatic step(input logic en, input logic br, input logic [31:0] ba, input logic rdy, input logic mrdy, input logic rsp);
        logic hit, e_valid, e_req, grant, pop;
        logic [31:0] e_addr, e_data;
        ent_t e;
        pf_en_i = en; pf_branch_i = br; pf_branch_addr_i = ba; pf_ready_i = rdy; instr_ready_i = mrdy;
        instr_valid_i = rsp && q.size() > 0;
        instr_rdata_i = instr_valid_i ? q[0].data : $urandom;
        @(negedge clk_i);
        s_req = instr_req_o; s_iaddr = instr_addr_o; s_valid = pf_valid_o;
        s_busy = pf_busy_o; s_paddr = pf_addr_o; s_instr = pf_instr_o;
        hit = 1'b0;
`ifdef BETA_PF_BYPASS_EN
        hit = f.size() == 0 && instr_valid_i && !q[0].drop && !br;
`endif
        e_valid = f.size() > 0 || hit;
        e_addr = f.size() > 0 ? f[0].addr : (q.size() > 0 ? q[0].addr : 32'h0);
        e_data = f.size() > 0 ? f[0].data : (q.size() > 0 ? q[0].data : 32'h0);
        e_req = en && !br && q.size() < 2 && f.size() + q.size() < 4;
        chk("instr_req_o", s_req, e_req);
        chk("instr_addr_o", s_iaddr, m_fetch);
        chk("pf_valid_o", s_valid, e_valid);
        chk("pf_busy_o", s_busy, q.size() > 0);
        if (e_valid) begin
            chk("pf_addr_o", s_paddr, e_addr);
            chk("pf_instr_o", s_instr, e_data);
        end
        grant = e_req && mrdy;
        pop = e_valid && rdy && !br;
        if (pop && f.size() > 0) void'(f.pop_front());
        if (instr_valid_i) begin
            e = q.pop_front();
            if (!e.drop && !br && !(hit && rdy)) f.push_back(e);
        end
        if (br) begin
            f.delete();
            foreach (q[i]) q[i].drop = 1'b1;
            m_fetch = ba & ~32'd3;
        end
        if (grant) begin
            q.push_back('{m_fetch, $urandom, 1'b0});
            m_fetch += 32'd4;
        end
        @(posedge clk_i);
        #1;
    endtask
    task automatic wait_first(input string nm, input logic [31:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (s_valid) begin
                seen = 1'b1;
                chk(nm, s_paddr, exp);
            end
        end
        if (!seen) chk({nm, " timeout"}, 0, 1);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        tbl[0] = '{1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0};
        tbl[1] = '{1, 1'b0, 1'b1, 32'h84, 1'b0, 32'h0};
        tbl[2] = '{1, 1'b0, 1'b1, 32'h88, 1'b1, 32'h80};
        tbl[3] = '{1, 1'b0, 1'b1, 32'h8C, 1'b1, 32'h80};
        tbl[4] = '{1, 1'b0, 1'b0, 32'h90, 1'b1, 32'h80};
        tbl[5] = '{16, 1'b0, 1'b0, 32'h90, 1'b1, 32'h80};
        tbl[6] = '{1, 1'b1, 1'b0, 32'h90, 1'b1, 32'h80};
        tbl[7] = '{1, 1'b1, 1'b1, 32'h90, 1'b1, 32'h84};
        tbl[8] = '{1, 1'b1, 1'b1, 32'h94, 1'b1, 32'h88};
        tbl[9] = '{1, 1'b1, 1'b1, 32'h98, 1'b1, 32'h8C};
        apply_reset();
`ifndef BETA_PF_BYPASS_EN
        foreach (tbl[r]) begin
            for (int k = 0; k < tbl[r].rep; k++) begin
                step(1'b1, 1'b0, 32'h0, tbl[r].rdy, 1'b1, 1'b1);
                chk("tbl req", s_req, tbl[r].req);
                chk("tbl iaddr", s_iaddr, tbl[r].iaddr);
                chk("tbl valid", s_valid, tbl[r].valid);
                if (tbl[r].valid) chk("tbl paddr", s_paddr, tbl[r].paddr);
            end
        end
`else
        apply_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("bypass valid", s_valid, 1);
        chk("bypass addr", s_paddr, 32'h80);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("bypass no push", s_valid, 0);
`endif
        apply_reset();
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("max outstanding req", s_req, 0);
        step(1'b1, 1'b1, 32'h203, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("branch iaddr", s_iaddr, 32'h200);
        chk("branch busy", s_busy, 1);
        wait_first("branch first paddr", 32'h200);
        apply_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h400, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("branch+rsp valid", s_valid, 0);
        chk("branch+rsp busy", s_busy, 0);
        chk("branch+rsp iaddr", s_iaddr, 32'h400);
        wait_first("branch+rsp first paddr", 32'h400);
        apply_reset();
        step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("wrap top", s_iaddr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("wrap zero", s_iaddr, 32'h0);
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] ba;
            if (c == 1500) apply_reset();
            ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0, ba,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
